iob_merge: RTL



---
 rtl/iob_merge.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/iob_merge.sv
// N-master to 1-slave IOb merger with round-robin arbitration.
// One transaction in flight; read responses return to the owning master.
module iob_merge #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                                                 clk_i,
    input  logic                                                 arst_i,
    input  logic                                                 cke_i,
    input  logic [N_MASTERS*(1+ADDR_W+DATA_W+DATA_W/8)-1:0]      m_req_i,
    output logic [N_MASTERS*(DATA_W+2)-1:0]                      m_resp_o,
    output logic [(1+ADDR_W+DATA_W+DATA_W/8)-1:0]                s_req_o,
    input  logic [(DATA_W+2)-1:0]                                s_resp_i
);

    localparam int          STRB_W = DATA_W / 8;
    localparam int          REQ_W  = 1 + ADDR_W + DATA_W + STRB_W;
    localparam int          RESP_W = DATA_W + 2;
    localparam int          MW     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int unsigned N_U    = N_MASTERS;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WAIT_R
    } state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   grant_q, grant_d;
    logic [MW-1:0]   ptr_q, ptr_d;

    logic [REQ_W-1:0]     req [N_MASTERS];
    logic [N_MASTERS-1:0] avalid;
    logic [REQ_W-1:0]     sel_req;
    logic                 sel_avalid;
    logic                 sel_write;
    logic                 s_ready;
    logic                 s_rvalid;
    logic [DATA_W-1:0]    s_rdata;
    logic                 accept;
    logic [MW-1:0]        grant_inc;

    logic                 arb_any;
    logic [MW-1:0]        arb_idx;
    logic                 found_hi;
    logic [MW-1:0]        hi_idx;
    logic [MW-1:0]        lo_idx;

    always_comb begin
        for (int unsigned k = 0; k < N_U; k++) begin
            req[k]    = m_req_i[k*REQ_W +: REQ_W];
            avalid[k] = req[k][REQ_W-1];
        end
    end

    always_comb begin
        sel_req = '0;
        for (int unsigned k = 0; k < N_U; k++) begin
            if (grant_q == MW'(k)) sel_req = req[k];
        end
    end

    assign sel_avalid = sel_req[REQ_W-1];
    assign sel_write  = |sel_req[STRB_W-1:0];
    assign s_ready    = s_resp_i[0];
    assign s_rvalid   = s_resp_i[1];
    assign s_rdata    = s_resp_i[RESP_W-1:2];
    assign accept     = (state_q == GRANT) && sel_avalid && s_ready;
    assign grant_inc  = (32'(grant_q) == N_U - 1) ? '0 : grant_q + MW'(1);

    // Rotating search: lowest requester at or above ptr, else lowest overall (wrap).
    always_comb begin
        arb_any  = 1'b0;
        found_hi = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned j = 0; j < N_U; j++) begin
            if (avalid[j]) begin
                if (!arb_any) begin
                    lo_idx  = MW'(j);
                    arb_any = 1'b1;
                end
                if (!found_hi && (j >= 32'(ptr_q))) begin
                    hi_idx   = MW'(j);
                    found_hi = 1'b1;
                end
            end
        end
        arb_idx = found_hi ? hi_idx : lo_idx;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else if (cke_i) begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_d = arb_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (accept) begin
                    // A zero-latency read completes in the acceptance cycle.
                    if (sel_write || s_rvalid) begin
                        ptr_d   = grant_inc;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_R;
                    end
                end else if (!sel_avalid) begin
                    state_d = IDLE;
                end
            end
            WAIT_R: begin
                if (s_rvalid) begin
                    ptr_d   = grant_inc;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_req_o          = sel_req;
        s_req_o[REQ_W-1] = (state_q == GRANT) && sel_avalid;
        m_resp_o         = '0;
        for (int unsigned k = 0; k < N_U; k++) begin
            m_resp_o[k*RESP_W+2 +: DATA_W] = s_rdata;
            if (grant_q == MW'(k)) begin
                m_resp_o[k*RESP_W]   = (state_q == GRANT) && s_ready;
                m_resp_o[k*RESP_W+1] = (state_q != IDLE) && s_rvalid;
            end
        end
    end

endmodule
